// File: rtl/priority_scan_encoder.sv
// Accepts a request vector, then emits the index of each set bit one beat at a time,
// in priority order, with a registered valid/ready output stream.
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] dataout,
  output logic                     out_last,
  output logic                     out_zero
);
  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] rem;
  logic [IDXW-1:0]  sel;

  // Last match in the loop wins, so loop direction sets the priority.
  function automatic logic [IDXW-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) if (v[i]) r = IDXW'(i);
    end else begin
      for (int i = WIDTH-1; i >= 0; i--) if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // The same encoder serves the first beat (from datain) and later beats (from pending).
  always_comb begin
    src = (state == IDLE) ? datain : pending;
    sel = pick(src);
    rem = src & ~({{(WIDTH-1){1'b0}}, 1'b1} << sel);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      dataout   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            state     <= SCAN;
            out_valid <= 1'b1;
            dataout   <= sel;
            pending   <= rem;
            out_last  <= (rem == '0);
            out_zero  <= (datain == '0);
          end
        end
        SCAN: begin
          if (flush || (out_ready && out_last)) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            dataout   <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
          end else if (out_ready) begin
            dataout  <= sel;
            pending  <= rem;
            out_last <= (rem == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Drives an MSB-first and an LSB-first encoder with shared stimulus and checks every
// presented beat against per-instance expected-beat queues.
module tb_priority_scan_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] datain = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       m_rdy, m_vld, m_last, m_zero;
  logic       l_rdy, l_vld, l_last, l_zero;
  logic [2:0] m_d, l_d;

  typedef struct packed {logic [2:0] idx; logic last; logic zero;} beat_t;
  beat_t q_m[$];
  beat_t q_l[$];
  logic [31:0] log_m, log_l;
  int cnt_m, cnt_l;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_rdy), .datain(datain),
    .flush(flush), .out_valid(m_vld), .out_ready(out_ready), .dataout(m_d),
    .out_last(m_last), .out_zero(m_zero));

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_rdy), .datain(datain),
    .flush(flush), .out_valid(l_vld), .out_ready(out_ready), .dataout(l_d),
    .out_last(l_last), .out_zero(l_zero));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_m = '0; log_l = '0; cnt_m = 0; cnt_l = 0;
  endtask

  task automatic push_model(input logic [7:0] v);
    int n, km, kl;
    n = $countones(v); km = 0; kl = 0;
    if (v == 8'h00) begin
      q_m.push_back({3'd0, 1'b1, 1'b1});
      q_l.push_back({3'd0, 1'b1, 1'b1});
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (v[7-j]) begin km++; q_m.push_back({3'(7-j), km == n, 1'b0}); end
        if (v[j])   begin kl++; q_l.push_back({3'(j), kl == n, 1'b0}); end
      end
    end
  endtask

  task automatic mon(input bit lsb, input logic v, input logic [2:0] d,
                     input logic l, input logic z);
    beat_t e;
    if (!v) begin
      chk(lsb ? "l_idle_out" : "m_idle_out", {27'd0, d, l, z}, 32'd0);
    end else begin
      chk(lsb ? "l_q_nonempty" : "m_q_nonempty", 32'(lsb ? q_l.size() > 0 : q_m.size() > 0), 32'd1);
      if (lsb ? q_l.size() > 0 : q_m.size() > 0) begin
        e = lsb ? q_l[0] : q_m[0];
        chk(lsb ? "l_beat" : "m_beat", {27'd0, d, l, z}, {27'd0, e});
        if (out_ready) begin
          if (lsb) begin void'(q_l.pop_front()); log_l = (log_l << 4) | 32'(d); cnt_l++; end
          else     begin void'(q_m.pop_front()); log_m = (log_m << 4) | 32'(d); cnt_m++; end
        end
      end
    end
  endtask

  // One cycle: check presented outputs at the negedge, then step past the next posedge.
  task automatic tick();
    @(negedge clk);
    if (rst_n && !flush) begin
      mon(1'b0, m_vld, m_d, m_last, m_zero);
      mon(1'b1, l_vld, l_d, l_last, l_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!(m_rdy && l_rdy) && n < 50) begin tick(); n++; end
    chk("send_wait", 32'(n < 50), 32'd1);
    in_valid = 1'b1; datain = v;
    push_model(v);
    tick();
    in_valid = 1'b0; datain = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0 || !m_rdy || !l_rdy) && n < 100) begin
      tick(); n++;
    end
    chk("drain_wait", 32'(n < 100), 32'd1);
  endtask

  initial begin
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {28'd0, m_rdy, m_vld, m_last, m_zero}, 32'b1000);
    chk("rst_data", {29'd0, m_d}, 32'd0);
    rst_n = 1'b1;

    // MSB-first scan with continuous ready
    out_ready = 1'b1;
    send(8'b01001111);
    chk("lat_valid", {30'd0, m_vld, l_vld}, 32'b11);
    drain();
    chk("msb_seq", log_m, 32'h63210);
    chk("idle_after", {31'd0, m_rdy}, 32'd1);

    // LSB-first ordering
    clear_logs();
    send(8'b00110010);
    drain();
    chk("lsb_seq", log_l, 32'h145);

    // All-zero vector
    clear_logs();
    send(8'h00);
    chk("zero_beat", {28'd0, m_vld, m_last, m_zero, m_rdy}, 32'b1110);
    drain();
    chk("zero_cnt", 32'(cnt_m), 32'd1);

    // Backpressure: ready toggles each cycle
    clear_logs();
    send(8'b11001101);
    for (int k = 0; k < 10; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    chk("stall_cnt", 32'(cnt_m), 32'd5);
    chk("stall_idle", {31'd0, m_rdy}, 32'd1);
    chk("stall_seq", log_m, 32'h76320);

    // Flush after three beats, then flush in IDLE blocks an accept
    clear_logs();
    send(8'hFF);
    repeat (3) tick();
    flush = 1'b1;
    q_m.delete(); q_l.delete();
    tick();
    flush = 1'b0;
    chk("flush_state", {28'd0, m_vld, m_rdy, l_vld, l_rdy}, 32'b0101);
    chk("flush_seq", log_m, 32'h765);
    flush = 1'b1; in_valid = 1'b1; datain = 8'hFF;
    tick();
    flush = 1'b0; in_valid = 1'b0; datain = '0;
    chk("flush_idle", {30'd0, m_vld, m_rdy}, 32'b01);
    clear_logs();
    send(8'b00000101);
    drain();
    chk("post_flush", log_m, 32'h20);

    // Asynchronous reset mid-scan
    clear_logs();
    send(8'b01001111);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {25'd0, m_vld, m_d, m_last, m_zero, m_rdy}, 32'b1);
    q_m.delete(); q_l.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_release", {30'd0, m_vld, m_rdy}, 32'b01);
    clear_logs();
    send(8'b00011100);
    drain();
    chk("post_rst", log_m, 32'h432);
    chk("post_rst_l", log_l, 32'h234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
